// File: rtl/seven_seg_scroll_display_if.sv
// Bundles the display's data, mode, button and pin signals between the
// calculator logic (master) and the seven-segment display driver (slave).
interface seven_seg_scroll_display_if #(
    parameter int DIGITS        = 4,
    parameter int VALUE_NIBBLES = 8
);
    logic [1:0]                   mode;
    logic [4*VALUE_NIBBLES-1:0]   value;
    logic [7*DIGITS-1:0]          raw_segs;
    logic                         up_button;
    logic                         down_button;
    logic                         center_button;
    logic [6:0]                   cathode;
    logic [DIGITS-1:0]            anode;
    logic [VALUE_NIBBLES-DIGITS:0] led;

    modport master (
        output mode, value, raw_segs, up_button, down_button, center_button,
        input  cathode, anode, led
    );

    modport slave (
        input  mode, value, raw_segs, up_button, down_button, center_button,
        output cathode, anode, led
    );
endinterface

// File: rtl/seven_seg_scroll_display.sv
// Multiplexed N-digit seven-segment driver with a button-scrolled hex window.
// Optional macro LEADING_ZERO_BLANK_EN blanks windowed nibbles above the top nonzero nibble.
module seven_seg_scroll_display #(
    parameter int DIGITS          = 4,
    parameter int VALUE_NIBBLES   = 8,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input logic clk,
    input logic rst,
    seven_seg_scroll_display_if.slave bus
);
    localparam int MAXOFF = VALUE_NIBBLES - DIGITS;
    localparam int LED_W  = MAXOFF + 1;
    localparam int OFF_W  = (MAXOFF > 0) ? $clog2(MAXOFF + 1) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB_W  = (VALUE_NIBBLES > 1) ? $clog2(VALUE_NIBBLES) : 1;
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [2:0]             btn_raw;
    logic [2:0]             sync1;
    logic [2:0]             sync2;
    logic [2:0]             level;
    logic [2:0][DEB_W-1:0]  deb_cnt;
    logic [2:0]             press;
    logic [OFF_W-1:0]       offset;
    logic [PRE_W-1:0]       prescaler;
    logic [IDX_W-1:0]       idx;
    logic [NIB_W-1:0]       nib_sel;
    logic [3:0]             nibble;
    logic [6:0]             raw_pat;
    logic [DIGITS-1:0]      anode_one;
    logic [DIGITS-1:0]      anode_next;
    logic [6:0]             cathode_next;
    logic [LED_W-1:0]       led_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NIB_W-1:0]       top_nz;
    logic                   blank_nib;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1111110;
            4'h1: hex_glyph = 7'b0110000;
            4'h2: hex_glyph = 7'b1101101;
            4'h3: hex_glyph = 7'b1111001;
            4'h4: hex_glyph = 7'b0110011;
            4'h5: hex_glyph = 7'b1011011;
            4'h6: hex_glyph = 7'b1011111;
            4'h7: hex_glyph = 7'b1110000;
            4'h8: hex_glyph = 7'b1111111;
            4'h9: hex_glyph = 7'b1111011;
            4'hA: hex_glyph = 7'b1110111;
            4'hB: hex_glyph = 7'b0011111;
            4'hC: hex_glyph = 7'b1001110;
            4'hD: hex_glyph = 7'b0111101;
            4'hE: hex_glyph = 7'b1001111;
            default: hex_glyph = 7'b1000111;
        endcase
    endfunction

    assign btn_raw = {bus.center_button, bus.down_button, bus.up_button};

    // Synchronize, then flip each debounced level only after a full run of differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int b = 0; b < 3; b++) begin
                if (sync2[b] == level[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[b]   <= ~level[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press = '0;
        for (int b = 0; b < 3; b++) begin
            press[b] = sync2[b] & ~level[b] & (deb_cnt[b] == DEB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Window offset: center wins, opposing up/down cancel, window pinned at 0 outside hex mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
        end else if (bus.mode != 2'b01) begin
            offset <= '0;
        end else if (press[2]) begin
            offset <= '0;
        end else if (press[0] && !press[1] && offset != OFF_W'(MAXOFF)) begin
            offset <= offset + 1'b1;
        end else if (press[1] && !press[0] && offset != '0) begin
            offset <= offset - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        nib_sel = NIB_W'(offset) + NIB_W'(idx);
        nibble  = '0;
        for (int n = 0; n < VALUE_NIBBLES; n++) begin
            if (nib_sel == NIB_W'(n)) nibble = bus.value[4*n +: 4];
        end
        raw_pat   = '0;
        anode_one = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                raw_pat      = bus.raw_segs[7*k +: 7];
                anode_one[k] = 1'b0;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        top_nz = '0;
        for (int n = 1; n < VALUE_NIBBLES; n++) begin
            if (bus.value[4*n +: 4] != 4'h0) top_nz = NIB_W'(n);
        end
        blank_nib = (nib_sel > top_nz);
`endif
        anode_next   = anode_one;
        cathode_next = 7'b1111111;
        case (bus.mode)
            2'b00: cathode_next = 7'b1111110;
            2'b01: begin
`ifdef LEADING_ZERO_BLANK_EN
                cathode_next = blank_nib ? 7'b1111111 : ~hex_glyph(nibble);
`else
                cathode_next = ~hex_glyph(nibble);
`endif
            end
            2'b10: cathode_next = ~raw_pat;
            default: anode_next = '1;
        endcase
        led_next = '0;
        if (bus.mode == 2'b01) begin
            for (int j = 0; j < LED_W; j++) begin
                if (offset == OFF_W'(j)) led_next[j] = 1'b1;
            end
        end
    end

    // Anode, cathode and LED bar all register on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.anode   <= '1;
            bus.cathode <= 7'b1111111;
            bus.led     <= '0;
        end else begin
            bus.anode   <= anode_next;
            bus.cathode <= cathode_next;
            bus.led     <= led_next;
        end
    end
endmodule

// File: tb/tb_seven_seg_scroll_display.sv
// Scoreboard bench for seven_seg_scroll_display: stimulus queues expected pin
// states per cycle, a negedge monitor pops and compares them.
module tb_seven_seg_scroll_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   scan_n = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] anode;
        logic [6:0] cathode;
        logic [4:0] led;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    localparam logic [6:0] C_0     = 7'b0000001;
    localparam logic [6:0] C_1     = 7'b1001111;
    localparam logic [6:0] C_2     = 7'b0010010;
    localparam logic [6:0] C_3     = 7'b0000110;
    localparam logic [6:0] C_4     = 7'b1001100;
    localparam logic [6:0] C_5     = 7'b0100100;
    localparam logic [6:0] C_A     = 7'b0001000;
    localparam logic [6:0] C_B     = 7'b1100000;
    localparam logic [6:0] C_C     = 7'b0110001;
    localparam logic [6:0] C_D     = 7'b1000010;
    localparam logic [6:0] C_DASH  = 7'b1111110;
    localparam logic [6:0] C_BLANK = 7'b1111111;

    seven_seg_scroll_display_if #(.DIGITS(4), .VALUE_NIBBLES(8)) bus ();

    seven_seg_scroll_display #(
        .DIGITS(4),
        .VALUE_NIBBLES(8),
        .REFRESH_DIV(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent model of the scan position: posedges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) scan_n <= 0;
        else     scan_n <= scan_n + 1;
    end

    task automatic push_exp(input string name, input logic [3:0] a,
                            input logic [6:0] c, input logic [4:0] l);
        exp_t e;
        e.cyc = cyc;
        e.name = name;
        e.anode = a;
        e.cathode = c;
        e.led = l;
        exp_q.push_back(e);
    endtask

    task automatic check_scan(input string name, input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3,
                              input logic [4:0] l, input bit blank, input int n);
        logic [6:0] cs [4];
        logic [3:0] one;
        logic [3:0] a;
        int k;
        cs = '{c0, c1, c2, c3};
        one = 4'b0001;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k = ((scan_n - 1) / 4) % 4;
            a = blank ? 4'b1111 : ~(one << k);
            push_exp(name, a, cs[k], l);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] btn, input int hold);
        @(posedge clk);
        #1;
        {bus.center_button, bus.down_button, bus.up_button} = btn;
        repeat (hold) @(posedge clk);
        #1;
        {bus.center_button, bus.down_button, bus.up_button} = 3'b000;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk);
        #1;
        bus.mode = m;
    endtask

    task automatic check_output(input exp_t e);
        n_checks++;
        if (e.cyc != cyc || bus.anode !== e.anode || bus.cathode !== e.cathode || bus.led !== e.led) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d(exp %0d): anode=%b cathode=%b led=%b, required anode=%b cathode=%b led=%b",
                     e.name, cyc, e.cyc, bus.anode, bus.cathode, bus.led, e.anode, e.cathode, e.led);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            check_output(mon_e);
        end
    end

    initial begin
        bus.mode = 2'b01;
        bus.value = 32'h1234_ABCD;
        bus.raw_segs = {7'b1001110, 7'b1110111, 7'b1101101, 7'b0110000};
        bus.up_button = 1'b0;
        bus.down_button = 1'b0;
        bus.center_button = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push_exp("reset_state", 4'b1111, C_BLANK, 5'b00000);
        rst = 1'b0;

        check_scan("hex_off0", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 16);
        check_scan("hex_off0_more", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 6);

        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp("reset_mid_scan", 4'b1111, C_BLANK, 5'b00000);
        @(posedge clk);
        #1;
        push_exp("reset_held", 4'b1111, C_BLANK, 5'b00000);
        rst = 1'b0;
        check_scan("scan_restart", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 16);

        repeat (3) apply_stimulus(3'b001, 8);
        check_scan("up_x3", C_A, C_4, C_3, C_2, 5'b01000, 1'b0, 16);

        repeat (5) apply_stimulus(3'b001, 8);
        check_scan("up_saturate", C_4, C_3, C_2, C_1, 5'b10000, 1'b0, 16);

        apply_stimulus(3'b011, 8);
        check_scan("up_down_same", C_4, C_3, C_2, C_1, 5'b10000, 1'b0, 8);

        apply_stimulus(3'b010, 8);
        check_scan("down_one", C_A, C_4, C_3, C_2, 5'b01000, 1'b0, 8);

        apply_stimulus(3'b101, 8);
        check_scan("center_up", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 8);

        apply_stimulus(3'b001, 2);
        check_scan("glitch", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 8);

        repeat (2) apply_stimulus(3'b001, 8);
        check_scan("offset2", C_B, C_A, C_4, C_3, 5'b00100, 1'b0, 8);

        set_mode(2'b00);
        check_scan("dash_mode", C_DASH, C_DASH, C_DASH, C_DASH, 5'b00000, 1'b0, 16);

        set_mode(2'b10);
        check_scan("raw_mode", 7'b1001111, 7'b0010010, 7'b0001000, 7'b0110001, 5'b00000, 1'b0, 16);

        set_mode(2'b01);
        check_scan("back_to_hex", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 8);

        set_mode(2'b11);
        check_scan("blank_mode", C_BLANK, C_BLANK, C_BLANK, C_BLANK, 5'b00000, 1'b1, 8);

        set_mode(2'b01);
        bus.value = 32'h0000_00A5;
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("value_a5", C_5, C_A, C_BLANK, C_BLANK, 5'b00001, 1'b0, 16);
`else
        check_scan("value_a5", C_5, C_A, C_0, C_0, 5'b00001, 1'b0, 16);
`endif

        @(posedge clk);
        #1;
        bus.value = 32'h0000_0000;
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("value_zero", C_0, C_BLANK, C_BLANK, C_BLANK, 5'b00001, 1'b0, 16);
`else
        check_scan("value_zero", C_0, C_0, C_0, C_0, 5'b00001, 1'b0, 16);
`endif

        @(posedge clk);
        #1;
        bus.value = 32'h1234_ABCD;
        bus.up_button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp("reset_mid_debounce", 4'b1111, C_BLANK, 5'b00000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_scan("held_no_pulse", C_D, C_C, C_B, C_A, 5'b00001, 1'b0, 4);
        repeat (4) @(posedge clk);
        check_scan("held_debounced", C_C, C_B, C_A, C_4, 5'b00010, 1'b0, 8);
        bus.up_button = 1'b0;

        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
